// File: rtl/rf_wb_pkg.sv
// Shared types and default sizes for the register-file writeback unit.
// Optional bypass search is enabled with RF_WB_BYPASS_EN.
package rf_wb_pkg;

    localparam int DefN     = 32;
    localparam int DefAddr  = 5;
    localparam int DefDepth = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } wbState_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Write-request queue: power-of-two depth, wrapping pointers, synchronous flush.
// With RF_WB_BYPASS_EN the raw entries and read pointer are exported.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int N     = DefN,
    parameter int ADDR  = DefAddr,
    parameter int DEPTH = DefDepth
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [ADDR-1:0]           pushAddr,
    input  logic [N-1:0]              pushData,
    input  logic                      pop,
    input  logic                      flush,
    output logic [ADDR-1:0]           headAddr,
    output logic [N-1:0]              headData,
    output logic [$clog2(DEPTH):0]    count
`ifdef RF_WB_BYPASS_EN
    ,
    output logic [$clog2(DEPTH)-1:0]  rdPtr,
    output logic [DEPTH-1:0][ADDR-1:0] entAddr,
    output logic [DEPTH-1:0][N-1:0]   entData
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0][ADDR-1:0] memAddr;
    logic [DEPTH-1:0][N-1:0]    memData;
    logic [PW-1:0]              wrPtr;
    logic [PW-1:0]              rdPtrQ;

    assign headAddr = memAddr[rdPtrQ];
    assign headData = memData[rdPtrQ];

`ifdef RF_WB_BYPASS_EN
    assign rdPtr   = rdPtrQ;
    assign entAddr = memAddr;
    assign entData = memData;
`endif

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr   <= '0;
            rdPtrQ  <= '0;
            count   <= '0;
            memAddr <= '0;
            memData <= '0;
        end else if (flush) begin
            wrPtr  <= '0;
            rdPtrQ <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                memAddr[wrPtr] <= pushAddr;
                memData[wrPtr] <= pushData;
                wrPtr          <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtrQ <= rdPtrQ + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/rf_writeback_unit.sv
// Queued register-file writeback with stall, flush and registered write port.
// Define RF_WB_BYPASS_EN to add two combinational read-bypass ports.
module rf_writeback_unit
    import rf_wb_pkg::*;
#(
    parameter int N     = DefN,
    parameter int ADDR  = DefAddr,
    parameter int DEPTH = DefDepth
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wb_valid_i,
    input  logic [ADDR-1:0]        wb_addr_i,
    input  logic [N-1:0]           wb_data_i,
    output logic                   wb_ready_o,
    input  logic                   stall_i,
    input  logic                   flush_i,
    output logic                   Reg_Write_o,
    output logic [ADDR-1:0]        Write_Register_o,
    output logic [N-1:0]           Write_Data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   busy_o
`ifdef RF_WB_BYPASS_EN
    ,
    input  logic [ADDR-1:0]        rd_addr_1_i,
    input  logic [ADDR-1:0]        rd_addr_2_i,
    output logic                   byp_hit_1_o,
    output logic                   byp_hit_2_o,
    output logic [N-1:0]           byp_data_1_o,
    output logic [N-1:0]           byp_data_2_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbState_e        state;
    logic            accept;
    logic            push;
    logic            pop;
    logic [CW-1:0]   nextCount;
    logic [ADDR-1:0] headAddr;
    logic [N-1:0]    headData;

`ifdef RF_WB_BYPASS_EN
    logic [PW-1:0]              rdPtr;
    logic [DEPTH-1:0][ADDR-1:0] entAddr;
    logic [DEPTH-1:0][N-1:0]    entData;
`endif

    assign wb_ready_o = count_o < CW'(DEPTH);
    assign accept     = wb_valid_i & wb_ready_o;
    // Writes to x0 finish the handshake but never enter the queue.
    assign push       = accept & (wb_addr_i != '0) & ~flush_i;
    assign pop        = (count_o != '0) & ~stall_i & ~flush_i;
    assign nextCount  = count_o + CW'(push) - CW'(pop);
    assign busy_o     = state != IDLE;

    rf_wb_fifo #(
        .N     (N),
        .ADDR  (ADDR),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushAddr (wb_addr_i),
        .pushData (wb_data_i),
        .pop      (pop),
        .flush    (flush_i),
        .headAddr (headAddr),
        .headData (headData),
        .count    (count_o)
`ifdef RF_WB_BYPASS_EN
        ,
        .rdPtr    (rdPtr),
        .entAddr  (entAddr),
        .entData  (entData)
`endif
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            Reg_Write_o      <= 1'b0;
            Write_Register_o <= '0;
            Write_Data_o     <= '0;
        end else begin
            Reg_Write_o <= pop;
            if (pop) begin
                Write_Register_o <= headAddr;
                Write_Data_o     <= headData;
            end
            if (flush_i || nextCount == '0) begin
                state <= IDLE;
            end else if (stall_i) begin
                state <= HOLD;
            end else begin
                state <= DRAIN;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    // Oldest-to-youngest scan so the last match (youngest) wins.
    function automatic logic [N:0] lookup(input logic [ADDR-1:0] ra);
        logic [N:0]    r;
        logic [PW-1:0] idx;
        r = '0;
        if (Reg_Write_o && Write_Register_o == ra) begin
            r = {1'b1, Write_Data_o};
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr + PW'(i);
            if (CW'(i) < count_o && entAddr[idx] == ra) begin
                r = {1'b1, entData[idx]};
            end
        end
        if (ra == '0) begin
            r = '0;
        end
        return r;
    endfunction

    always_comb begin
        {byp_hit_1_o, byp_data_1_o} = lookup(rd_addr_1_i);
        {byp_hit_2_o, byp_data_2_o} = lookup(rd_addr_2_i);
    end
`endif

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Directed self-checking bench for rf_writeback_unit (default sizes).
// Bypass vectors run only when RF_WB_BYPASS_EN is defined.
module tb_rf_writeback_unit;
    import rf_wb_pkg::*;

    localparam int N     = 32;
    localparam int ADDR  = 5;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            wbValid = 1'b0;
    logic [ADDR-1:0] wbAddr = '0;
    logic [N-1:0]    wbData = '0;
    logic            wbReady;
    logic            stall = 1'b0;
    logic            flush = 1'b0;
    logic            regWrite;
    logic [ADDR-1:0] writeReg;
    logic [N-1:0]    writeData;
    logic [2:0]      count;
    logic            busy;
`ifdef RF_WB_BYPASS_EN
    logic [ADDR-1:0] rdAddr1 = '0;
    logic [ADDR-1:0] rdAddr2 = '0;
    logic            hit1;
    logic            hit2;
    logic [N-1:0]    bypData1;
    logic [N-1:0]    bypData2;
`endif

    int assertCnt = 0;
    int failCnt   = 0;

    rf_writeback_unit #(
        .N     (N),
        .ADDR  (ADDR),
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_valid_i       (wbValid),
        .wb_addr_i        (wbAddr),
        .wb_data_i        (wbData),
        .wb_ready_o       (wbReady),
        .stall_i          (stall),
        .flush_i          (flush),
        .Reg_Write_o      (regWrite),
        .Write_Register_o (writeReg),
        .Write_Data_o     (writeData),
        .count_o          (count),
        .busy_o           (busy)
`ifdef RF_WB_BYPASS_EN
        ,
        .rd_addr_1_i      (rdAddr1),
        .rd_addr_2_i      (rdAddr2),
        .byp_hit_1_o      (hit1),
        .byp_hit_2_o      (hit2),
        .byp_data_1_o     (bypData1),
        .byp_data_2_o     (bypData2)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        assertCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushReq(input logic [ADDR-1:0] a, input logic [N-1:0] d);
        wbValid = 1'b1;
        wbAddr  = a;
        wbData  = d;
        tick();
        wbValid = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        checkVal("rst_ready", wbReady, 1);
        checkVal("rst_count", count, 0);
        checkVal("rst_we", regWrite, 0);
        checkVal("rst_waddr", writeReg, 0);
        checkVal("rst_wdata", writeData, 0);
        checkVal("rst_busy", busy, 0);
        tick();
        reset = 1'b1;
        tick();

        // single write latency
        pushReq(5'd3, 32'hDEADBEEF);
        checkVal("lat_e0_count", count, 1);
        checkVal("lat_e0_we", regWrite, 0);
        checkVal("lat_e0_busy", busy, 1);
        tick();
        checkVal("lat_e1_we", regWrite, 1);
        checkVal("lat_e1_addr", writeReg, 3);
        checkVal("lat_e1_data", writeData, 32'hDEADBEEF);
        checkVal("lat_e1_count", count, 0);
        tick();
        checkVal("lat_e2_we", regWrite, 0);
        checkVal("lat_e2_addr_hold", writeReg, 3);
        checkVal("lat_e2_data_hold", writeData, 32'hDEADBEEF);
        checkVal("lat_e2_busy", busy, 0);

        // x0 write dropped
        checkVal("x0_ready", wbReady, 1);
        pushReq(5'd0, 32'hFFFFFFFF);
        checkVal("x0_count", count, 0);
        checkVal("x0_busy", busy, 0);
        tick();
        checkVal("x0_we", regWrite, 0);

        // fill under stall, then drain in order
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkVal($sformatf("fill_ready%0d", i), wbReady, (i < 4) ? 1 : 0);
            pushReq(ADDR'(i + 1), 32'h100 + i);
        end
        checkVal("fill_count", count, 4);
        checkVal("fill_ready", wbReady, 0);
        checkVal("fill_state", dut.state, HOLD);
        checkVal("fill_busy", busy, 1);
        checkVal("fill_we", regWrite, 0);
        stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal($sformatf("drain_we%0d", i), regWrite, 1);
            checkVal($sformatf("drain_addr%0d", i), writeReg, i + 1);
            checkVal($sformatf("drain_data%0d", i), writeData, 32'h100 + i);
            checkVal($sformatf("drain_count%0d", i), count, 3 - i);
        end
        tick();
        checkVal("drain_end_we", regWrite, 0);
        checkVal("drain_end_state", dut.state, IDLE);

        // flush with concurrent request
        stall = 1'b1;
        pushReq(5'd9, 32'h9);
        pushReq(5'd10, 32'hA);
        pushReq(5'd11, 32'hB);
        checkVal("fl_pre_count", count, 3);
        flush = 1'b1;
        pushReq(5'd12, 32'hC);
        flush = 1'b0;
        checkVal("fl_count", count, 0);
        checkVal("fl_we", regWrite, 0);
        checkVal("fl_state", dut.state, IDLE);
        checkVal("fl_busy", busy, 0);
        stall = 1'b0;
        tick();
        checkVal("fl_after_we", regWrite, 0);
        checkVal("fl_after_count", count, 0);

        // push and pop on the same edge
        pushReq(5'd4, 32'h44);
        checkVal("pp_count1", count, 1);
        checkVal("pp_we0", regWrite, 0);
        pushReq(5'd6, 32'h66);
        checkVal("pp_count_same", count, 1);
        checkVal("pp_we1", regWrite, 1);
        checkVal("pp_addr1", writeReg, 4);
        tick();
        checkVal("pp_we2", regWrite, 1);
        checkVal("pp_addr2", writeReg, 6);
        checkVal("pp_data2", writeData, 32'h66);
        checkVal("pp_count0", count, 0);
        tick();

        // reset in the middle of a drain
        stall = 1'b1;
        pushReq(5'd13, 32'hD);
        pushReq(5'd14, 32'hE);
        stall = 1'b0;
        tick();
        checkVal("mid_we", regWrite, 1);
        checkVal("mid_count", count, 1);
        #2;
        reset = 1'b0;
        #1;
        checkVal("mr_we", regWrite, 0);
        checkVal("mr_addr", writeReg, 0);
        checkVal("mr_data", writeData, 0);
        checkVal("mr_count", count, 0);
        checkVal("mr_ready", wbReady, 1);
        checkVal("mr_busy", busy, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal($sformatf("mr_post_we%0d", i), regWrite, 0);
        end

`ifdef RF_WB_BYPASS_EN
        // youngest queued match wins
        stall = 1'b1;
        pushReq(5'd7, 32'h11);
        pushReq(5'd7, 32'h22);
        rdAddr1 = 5'd7;
        rdAddr2 = 5'd0;
        #1;
        checkVal("byp_hit1", hit1, 1);
        checkVal("byp_data1", bypData1, 32'h22);
        checkVal("byp_hit2_x0", hit2, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        stall = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCnt, failCnt);
        $finish;
    end

endmodule
